// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: owner/HSIZE encodings and bus widths; AHB_ADDR_WIDTH/AHB_DATA_WIDTH default to 32 unless ahb_defines.vh sets them.
`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif
package mem_arb_pkg;
  localparam int AW = `AHB_ADDR_WIDTH;
  localparam int DW = `AHB_DATA_WIDTH;
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;
  localparam logic [2:0] SZ_BYTE = 3'b000;
  localparam logic [2:0] SZ_HALF = 3'b001;
  localparam logic [2:0] SZ_WORD = 3'b010;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: winner selection; MEM_ARB_RR_EN picks round robin, otherwise data over fetch.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  owner_t ptr,
  output owner_t winner,
  output logic   valid
);
  assign valid = i_req | d_req;
`ifdef MEM_ARB_RR_EN
  assign winner = (i_req & d_req) ? (ptr == OWN_D ? OWN_I : OWN_D) : (d_req ? OWN_D : OWN_I);
`else
  // ptr only steers the don't-care idle case
  assign winner = d_req ? OWN_D : (i_req ? OWN_I : ptr);
`endif
endmodule

// File: rtl/mem_port_arb.sv
// mem_port_arb: fetch/data port arbiter onto one pipelined AHB memory slave.
// Define MEM_ARB_RR_EN for round-robin arbitration (default: fixed priority, data first).
module mem_port_arb
  import mem_arb_pkg::*;
(
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_done,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  input  logic          d_write,
  input  logic [2:0]    d_size,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          HSEL,
  output logic [AW-1:0] HADDR,
  output logic [2:0]    HSIZE,
  output logic          HWRITE,
  output logic [DW-1:0] HWDATA,
  input  logic          HREADY,
  input  logic [DW-1:0] HRDATA
);
  owner_t ptr, winner, dp_owner;
  logic valid, run, gnt, d_win, dp_valid, dp_write;
  logic [DW-1:0] wdata_q, i_rdata_q, d_rdata_q;
  mem_arb_pick u_pick (
    .i_req  (i_req),
    .d_req  (d_req),
    .ptr    (ptr),
    .winner (winner),
    .valid  (valid)
  );
  assign run   = ~HRESET & HREADY;
  assign gnt   = run & valid;
  assign d_win = winner == OWN_D;
  always_comb begin
    HSEL    = gnt;
    i_gnt   = gnt & ~d_win;
    d_gnt   = gnt & d_win;
    HADDR   = gnt ? (d_win ? d_addr : i_addr) : '0;
    HSIZE   = gnt ? (d_win ? d_size : SZ_WORD) : '0;
    HWRITE  = gnt & d_win & d_write;
    HWDATA  = (~HRESET & dp_valid) ? wdata_q : '0;
    i_done  = run & dp_valid & (dp_owner == OWN_I);
    d_done  = run & dp_valid & (dp_owner == OWN_D);
    i_rdata = HRESET ? '0 : (i_done ? HRDATA : i_rdata_q);
    d_rdata = HRESET ? '0 : ((d_done & ~dp_write) ? HRDATA : d_rdata_q);
  end
  // tracker advances only on HREADY, so a stalled data phase keeps its state and HWDATA
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_valid  <= 1'b0;
      dp_owner  <= OWN_I;
      dp_write  <= 1'b0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else if (HREADY) begin
      dp_valid  <= valid;
      dp_owner  <= winner;
      dp_write  <= valid & d_win & d_write;
      wdata_q   <= (valid & d_win) ? d_wdata : '0;
      if (i_done) i_rdata_q <= HRDATA;
      if (d_done & ~dp_write) d_rdata_q <= HRDATA;
    end
  end
`ifdef MEM_ARB_RR_EN
  // last-owner pointer; resetting to fetch lets data win the first contention
  always_ff @(posedge HCLK) begin
    if (HRESET) ptr <= OWN_I;
    else if (gnt) ptr <= winner;
  end
`else
  assign ptr = OWN_I;
`endif
endmodule

// File: tb/tb_mem_port_arb.sv
// tb_mem_port_arb: scoreboard bench for mem_port_arb with a one-cycle-latency slave model.
module tb_mem_port_arb;
  import mem_arb_pkg::*;
  logic          HCLK, HRESET, HREADY;
  logic          i_req, i_gnt, i_done;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_write, d_gnt, d_done;
  logic [AW-1:0] d_addr;
  logic [2:0]    d_size;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          HSEL, HWRITE;
  logic [AW-1:0] HADDR, s_addr;
  logic [2:0]    HSIZE;
  logic [DW-1:0] HWDATA, HRDATA;
  int checks = 0;
  int errors = 0;
  typedef struct {logic own; logic wr; logic [DW-1:0] data;} exp_t;
  exp_t q[$];
  exp_t e;
  logic exp_d;

  mem_port_arb dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_write(d_write), .d_size(d_size), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .HSEL(HSEL), .HADDR(HADDR), .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(HRDATA)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction

  always @(posedge HCLK)
    if (HRESET) s_addr <= '0;
    else if (HSEL && HREADY) s_addr <= HADDR;
  assign HRDATA = mem_val(s_addr);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic smp();
    @(negedge HCLK);
  endtask

  always @(negedge HCLK)
    if (i_done || d_done) begin
      if (q.size() == 0) chk("sb_unexpected_done", 1, 0);
      else begin
        e = q.pop_front();
        chk("sb_owner", d_done, e.own);
        if (e.wr) chk("sb_wdata", HWDATA, e.data);
        else chk("sb_rdata", d_done ? d_rdata : i_rdata, e.data);
      end
    end

  initial begin
    HRESET = 1; HREADY = 1; i_req = 1; d_req = 1; i_addr = 32'h300; d_addr = 32'h400;
    d_write = 0; d_size = SZ_WORD; d_wdata = 32'h55AA55AA;
    step(); step(); smp();
    chk("rst_hsel", HSEL, 0);
    chk("rst_gnt", {i_gnt, d_gnt}, 0);
    chk("rst_haddr", HADDR, 0);
    chk("rst_hsize", HSIZE, 0);
    chk("rst_hwdata", HWDATA, 0);
    chk("rst_rdata", {i_rdata, d_rdata}, 0);
    step(); HRESET = 0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
`ifdef MEM_ARB_RR_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      smp();
      chk("both_dgnt", d_gnt, exp_d);
      chk("both_ignt", i_gnt, !exp_d);
      q.push_back(exp_d ? '{own: 1'b1, wr: 1'b0, data: mem_val(32'h400)}
                        : '{own: 1'b0, wr: 1'b0, data: mem_val(32'h300)});
    end
    step(); i_req = 0; d_req = 0;
    smp();
    chk("idle_hsel", HSEL, 0);
    chk("idle_addr", {HADDR, HSIZE, HWRITE}, 0);
    step(); i_req = 1; i_addr = 32'h100;
    smp();
    chk("f_gnt", i_gnt, 1);
    chk("f_haddr", HADDR, 32'h100);
    chk("f_hsize", HSIZE, SZ_WORD);
    chk("f_hwrite", HWRITE, 0);
    q.push_back('{own: 1'b0, wr: 1'b0, data: 32'hDEADBEEF});
    step(); i_req = 0;
    smp();
    chk("f_done", i_done, 1);
    chk("f_rdata", i_rdata, 32'hDEADBEEF);
    step(); smp();
    chk("f_done_pulse", i_done, 0);
    chk("f_rdata_hold", i_rdata, 32'hDEADBEEF);
    step(); d_req = 1; d_write = 1; d_addr = 32'h203; d_size = SZ_BYTE; d_wdata = 32'h11223344;
    smp();
    chk("w_gnt", d_gnt, 1);
    chk("w_haddr", HADDR, 32'h203);
    chk("w_hsize", HSIZE, SZ_BYTE);
    chk("w_hwrite", HWRITE, 1);
    chk("w_hwdata_addr_phase", HWDATA, 0);
    q.push_back('{own: 1'b1, wr: 1'b1, data: 32'h11223344});
    step(); d_req = 0; d_wdata = 0;
    smp();
    chk("w_done", d_done, 1);
    chk("w_hwdata", HWDATA, 32'h11223344);
    d_write = 0; d_size = SZ_WORD;
    for (int k = 0; k < 3; k++) begin
      step(); d_req = 1; d_addr = 32'(k * 4);
      smp();
      chk("b2b_gnt", d_gnt, 1);
      chk("b2b_haddr", HADDR, 32'(k * 4));
      chk("b2b_done", d_done, k > 0);
      q.push_back('{own: 1'b1, wr: 1'b0, data: mem_val(32'(k * 4))});
    end
    step(); d_req = 0;
    smp();
    chk("b2b_done_last", d_done, 1);
    step(); d_req = 1; d_write = 1; d_addr = 32'h500; d_wdata = 32'hCAFEF00D;
    smp();
    chk("st_gnt", d_gnt, 1);
    q.push_back('{own: 1'b1, wr: 1'b1, data: 32'hCAFEF00D});
    for (int k = 0; k < 2; k++) begin
      step(); d_req = 0; d_write = 0; d_wdata = 0; HREADY = 0; i_req = 1; i_addr = 32'h600;
      smp();
      chk("st_nognt", {i_gnt, d_gnt, HSEL}, 0);
      chk("st_nodone", d_done, 0);
      chk("st_hwdata", HWDATA, 32'hCAFEF00D);
    end
    step(); HREADY = 1;
    smp();
    chk("st_done", d_done, 1);
    chk("st_hwdata_done", HWDATA, 32'hCAFEF00D);
    chk("st_pipe_gnt", i_gnt, 1);
    q.push_back('{own: 1'b0, wr: 1'b0, data: mem_val(32'h600)});
    step(); i_req = 0;
    smp();
    chk("st_pipe_done", i_done, 1);
    step(); d_req = 1; d_addr = 32'h700;
    smp();
    chk("r_gnt", d_gnt, 1);
    step(); d_req = 0; HRESET = 1;
    smp();
    chk("r_nodone", {i_done, d_done}, 0);
    chk("r_outs", {HSEL, HWRITE, HADDR, HSIZE}, 0);
    chk("r_hwdata", HWDATA, 0);
    chk("r_rdata", {i_rdata, d_rdata}, 0);
    step(); HRESET = 0;
    smp();
    chk("r_after_done", {i_done, d_done}, 0);
    chk("r_after_rdata", {i_rdata, d_rdata}, 0);
    chk("r_after_hsel", HSEL, 0);
    step(); smp();
    chk("sb_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
